// File: rtl/at_cmd_sequencer.sv
// rtl/at_cmd_sequencer.sv - AT command sender with OK/ERROR reply judge and retry
module at_cmd_sequencer #(
   parameter int CLK_FREQ   = 50000000,
   parameter int TIMEOUT_MS = 1000,
   parameter int MAX_RETRY  = 3,
   parameter int CMD_LEN    = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [CMD_LEN*8-1:0]         cmd_data,
   input  logic [$clog2(CMD_LEN+1)-1:0] cmd_len,
   output logic                         tx_start,
   output logic [7:0]                   tx_data,
   input  logic                         tx_busy,
   input  logic                         rx_ready,
   input  logic [7:0]                   rx_data,
   output logic                         busy,
   output logic                         done,
   output logic                         ok,
   output logic                         err,
   output logic [1:0]                   attempts,
   output logic                         echo_valid,
   output logic [7:0]                   echo_byte
);

   localparam int LEN_W = $clog2(CMD_LEN + 1);
   localparam int IDX_W = (CMD_LEN > 1) ? $clog2(CMD_LEN) : 1;
   localparam int DIV   = CLK_FREQ / 1000;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int MS_W  = $clog2(TIMEOUT_MS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_HOLD, S_WAIT_TX, S_SEND_CR, S_WAIT_RESP, S_FINISH
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CMD_LEN*8-1:0] r_cmd;
   logic [LEN_W-1:0]     r_len;
   logic [LEN_W-1:0]     r_idx;
   logic [DIV_W-1:0]     r_div;
   logic [MS_W-1:0]      r_ms;
   logic [7:0]           r_prev;
   logic                 r_ok;
   logic                 r_err;
   logic [1:0]           r_attempts;

   logic [7:0]           w_bytes [CMD_LEN];
   logic [7:0]           w_cur_byte;
   logic                 w_len_bad;
   logic                 w_more_bytes;
   logic                 w_tick;
   logic                 w_timeout;
   logic                 w_rx_ok;
   logic                 w_rx_er;
   logic                 w_fail;
   logic                 w_can_retry;

   // Unpack the shadowed command so byte 0 is the most significant byte
   for (genvar g = 0; g < CMD_LEN; g++) begin : g_bytes
      assign w_bytes[g] = r_cmd[(CMD_LEN-1-g)*8 +: 8];
   end

   assign w_cur_byte   = w_bytes[r_idx[IDX_W-1:0]];
   assign w_len_bad    = (cmd_len == '0) || (cmd_len > LEN_W'(CMD_LEN));
   assign w_more_bytes = r_idx < (r_len - LEN_W'(1));
   assign w_tick       = (r_div == DIV_W'(DIV - 1));
   // The tick that would carry the ms counter onto TIMEOUT_MS ends the window
   assign w_timeout    = w_tick && (r_ms == MS_W'(TIMEOUT_MS - 1));
   assign w_rx_ok      = rx_ready && (r_prev == 8'h4F) && (rx_data == 8'h4B);
   assign w_rx_er      = rx_ready && (r_prev == 8'h45) && (rx_data == 8'h52);
   assign w_fail       = w_rx_er || w_timeout;
   assign w_can_retry  = r_attempts < 2'(MAX_RETRY);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decision; an OK match takes priority over a same-cycle timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (start) w_next = w_len_bad ? S_FINISH : S_SEND;
         S_SEND:      if (!tx_busy) w_next = S_HOLD;
         S_HOLD:      w_next = S_WAIT_TX;
         S_WAIT_TX:   if (!tx_busy) w_next = w_more_bytes ? S_SEND : S_SEND_CR;
         S_SEND_CR:   if (!tx_busy) w_next = S_WAIT_RESP;
         S_WAIT_RESP: begin
            if (w_rx_ok)     w_next = S_FINISH;
            else if (w_fail) w_next = w_can_retry ? S_SEND : S_FINISH;
         end
         S_FINISH:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Output decode: transmit strobes, busy and the done pulse
   always_comb begin
      tx_start = 1'b0;
      tx_data  = 8'h00;
      busy     = (r_state != S_IDLE);
      done     = 1'b0;
      case (r_state)
         S_SEND: if (!tx_busy) begin
            tx_start = 1'b1;
            tx_data  = w_cur_byte;
         end
         S_SEND_CR: if (!tx_busy) begin
            tx_start = 1'b1;
            tx_data  = 8'h0D;
         end
         S_FINISH: done = 1'b1;
         default: ;
      endcase
   end

   // Shadow registers, byte index, response timer, match register and result flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cmd      <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_div      <= '0;
         r_ms       <= '0;
         r_prev     <= '0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_attempts <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_cmd      <= cmd_data;
               r_len      <= cmd_len;
               r_idx      <= '0;
               r_ok       <= 1'b0;
               r_err      <= w_len_bad;
               r_attempts <= '0;
            end
            S_WAIT_TX: if (!tx_busy && w_more_bytes) r_idx <= r_idx + LEN_W'(1);
            S_SEND_CR: if (!tx_busy) begin
               r_div  <= '0;
               r_ms   <= '0;
               r_prev <= '0;
            end
            S_WAIT_RESP: begin
               r_div <= w_tick ? '0 : r_div + DIV_W'(1);
               if (w_tick) r_ms <= r_ms + MS_W'(1);
               if (rx_ready) r_prev <= rx_data;
               if (w_rx_ok) begin
                  r_ok <= 1'b1;
               end else if (w_fail) begin
                  if (w_can_retry) begin
                     r_attempts <= r_attempts + 2'd1;
                     r_idx      <= '0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign ok         = r_ok;
   assign err        = r_err;
   assign attempts   = r_attempts;
   assign echo_valid = tx_start;
   assign echo_byte  = tx_data;

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// tb/tb_at_cmd_sequencer.sv - table-driven and randomized bench for at_cmd_sequencer
module tb_at_cmd_sequencer;

   localparam int CLK_FREQ   = 10000;
   localparam int TIMEOUT_MS = 5;
   localparam int MAX_RETRY  = 2;
   localparam int CMD_LEN    = 16;
   localparam int TO_CYC     = TIMEOUT_MS * (CLK_FREQ / 1000) + 1;
   localparam int BUDGET     = 3000;

   logic          clk, rst_n, start;
   logic [127:0]  cmd_data;
   logic [4:0]    cmd_len;
   logic          tx_start, tx_busy, rx_ready;
   logic [7:0]    tx_data, rx_data;
   logic          busy, done, ok, err, echo_valid;
   logic [1:0]    attempts;
   logic [7:0]    echo_byte;

   at_cmd_sequencer #(
      .CLK_FREQ(CLK_FREQ), .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY), .CMD_LEN(CMD_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy), .done(done),
      .ok(ok), .err(err), .attempts(attempts),
      .echo_valid(echo_valid), .echo_byte(echo_byte)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transmitter model: busy for 8 cycles after each accepted byte
   logic pend;
   int   busy_cnt;
   initial begin pend = 1'b0; busy_cnt = 0; tx_busy = 1'b0; end
   always @(negedge clk) pend = tx_start;
   always @(posedge clk) begin
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (pend) busy_cnt = 8;
      tx_busy = (busy_cnt > 0);
   end

   // plan: 2 bits per attempt (attempt 0 in LSBs); 0 = silent, 1 = OK reply, 2 = ERROR reply
   typedef struct packed {
      logic [127:0] cmd;
      logic [4:0]   len;
      logic [5:0]   plan;
      logic         echo;
      logic         restart;
      logic         start_on_done;
      logic         exp_ok;
      logic         exp_err;
      logic [1:0]   exp_att;
   } vec_t;

   typedef struct {
      int         cyc;
      logic [7:0] b;
   } rx_ev_t;

   rx_ev_t rxq[$];
   int     last_sched;
   int     n_vec, n_err;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [127:0] pack_str(input string s);
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < s.len() && i < CMD_LEN; i++) v[8*(CMD_LEN-1-i) +: 8] = s[i];
      return v;
   endfunction

   function automatic logic [5:0] pl(input int p0, input int p1, input int p2);
      return {2'(p2), 2'(p1), 2'(p0)};
   endfunction

   function automatic vec_t mk(input string s, input int len, input logic [5:0] plan,
                               input bit echo, input bit restart, input bit sod,
                               input bit e_ok, input bit e_err, input int e_att);
      vec_t v;
      v.cmd = pack_str(s); v.len = 5'(len); v.plan = plan;
      v.echo = echo; v.restart = restart; v.start_on_done = sod;
      v.exp_ok = e_ok; v.exp_err = e_err; v.exp_att = 2'(e_att);
      return v;
   endfunction

   // Reference outcome: the first attempt answered with OK wins; otherwise every attempt is spent
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit   found;
      r = v; found = 1'b0;
      r.exp_ok = 1'b0; r.exp_err = 1'b1; r.exp_att = 2'd0;
      if (v.len != 0 && v.len <= CMD_LEN) begin
         r.exp_att = 2'(MAX_RETRY);
         for (int a = 0; a <= MAX_RETRY; a++) begin
            if (!found && v.plan[2*a +: 2] == 2'd1) begin
               found = 1'b1; r.exp_ok = 1'b1; r.exp_err = 1'b0; r.exp_att = 2'(a);
            end
         end
      end
      return r;
   endfunction

   task automatic sched_reply(input int cyc, input logic [1:0] p);
      logic [7:0] okb [6];
      logic [7:0] erb [9];
      rx_ev_t     e;
      int         t;
      okb = '{8'h0D, 8'h0A, 8'h4F, 8'h4B, 8'h0D, 8'h0A};
      erb = '{8'h0D, 8'h0A, 8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, 8'h0D, 8'h0A};
      t = ((last_sched > cyc) ? last_sched : cyc) + int'($urandom_range(2, 6));
      if (p == 2'd1) begin
         for (int i = 0; i < 6; i++) begin
            e.cyc = t; e.b = okb[i]; rxq.push_back(e); last_sched = t;
            t += int'($urandom_range(1, 3));
         end
      end else if (p == 2'd2) begin
         for (int i = 0; i < 9; i++) begin
            e.cyc = t; e.b = erb[i]; rxq.push_back(e); last_sched = t;
            t += int'($urandom_range(1, 3));
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] obs[$];
      rx_ev_t     e;
      int         L, nb, pos, a, cr_cyc, nexp, cnt;
      bit         bad, seen_done;
      L    = int'(v.len);
      bad  = (L == 0) || (L > CMD_LEN);
      nexp = bad ? 0 : (v.exp_ok ? int'(v.exp_att) + 1 : MAX_RETRY + 1);
      repeat (12) @(negedge clk);
      rxq.delete(); last_sched = 0;
      cmd_data = v.cmd; cmd_len = v.len; start = 1'b1;
      nb = 0; cr_cyc = 0; seen_done = 1'b0;
      for (int cyc = 1; cyc <= BUDGET && !seen_done; cyc++) begin
         @(negedge clk);
         start = 1'b0; rx_ready = 1'b0;
         if (cyc == 1) begin
            cmd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            cmd_len  = 5'($urandom_range(0, 31));
         end
         if (v.restart && cyc == 15) start = 1'b1;
         check("echo_mirror", 32'({echo_valid, echo_byte}), 32'({tx_start, tx_data}));
         check("ok_err_exclusive", 32'(ok & err), 32'd0);
         if (tx_start) begin
            obs.push_back(tx_data); nb++;
            if (nb == 1) check("first_tx_latency", 32'(cyc), 32'd1);
            if (!bad) begin
               pos = nb % (L + 1);
               if (pos == 1) begin
                  rxq.delete(); last_sched = cyc;
                  if (nb > 1) begin
                     a = (nb - 1) / (L + 1) - 1;
                     if (v.plan[2*a +: 2] == 2'd0) check("timeout_gap", 32'(cyc - cr_cyc), 32'(TO_CYC));
                  end
                  if (v.echo) begin
                     e.cyc = cyc + 1; e.b = 8'h4F; rxq.push_back(e);
                     e.cyc = cyc + 2; e.b = 8'h4B; rxq.push_back(e);
                     last_sched = cyc + 2;
                  end
               end
               if (pos == 0) begin
                  cr_cyc = cyc;
                  a = nb / (L + 1) - 1;
                  if (a <= MAX_RETRY) sched_reply(cyc, v.plan[2*a +: 2]);
               end
            end
         end
         if (rxq.size() > 0 && rxq[0].cyc <= cyc) begin
            e = rxq.pop_front();
            rx_ready = 1'b1; rx_data = e.b;
         end
         if (done) begin
            seen_done = 1'b1;
            check("done_ok", 32'(ok), 32'(v.exp_ok));
            check("done_err", 32'(err), 32'(v.exp_err));
            check("done_attempts", 32'(attempts), 32'(v.exp_att));
            if (bad) check("badlen_done_latency", 32'(cyc), 32'd1);
            if (!bad && nb > 0 && (nb % (L + 1)) == 0) begin
               a = nb / (L + 1) - 1;
               if (a <= MAX_RETRY && v.plan[2*a +: 2] == 2'd0)
                  check("final_timeout_gap", 32'(cyc - cr_cyc), 32'(TO_CYC));
            end
            if (v.start_on_done) start = 1'b1;
         end
      end
      check("done_seen", 32'(seen_done), 32'd1);
      @(negedge clk);
      start = 1'b0; rx_ready = 1'b0;
      check("done_one_cycle", 32'({done, busy}), 32'd0);
      check("ok_held", 32'({ok, err}), 32'({v.exp_ok, v.exp_err}));
      if (v.start_on_done) begin
         cnt = 0;
         repeat (6) begin
            @(negedge clk);
            if (tx_start || busy) cnt++;
         end
         check("start_on_done_ignored", 32'(cnt), 32'd0);
      end
      check("tx_count", 32'(obs.size()), 32'(nexp * (L + 1)));
      for (int i = 0; i < obs.size() && i < nexp * (L + 1); i++) begin
         if ((i % (L + 1)) == L) check("tx_cr", 32'(obs[i]), 32'h0D);
         else check("tx_byte", 32'(obs[i]), 32'(v.cmd[8*(CMD_LEN-1-(i % (L + 1))) +: 8]));
      end
   endtask

   task automatic reset_mid_seq();
      int  nb, cnt;
      bit  reached;
      repeat (12) @(negedge clk);
      cmd_data = pack_str("AT"); cmd_len = 5'd2; start = 1'b1;
      nb = 0; reached = 1'b0;
      for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (tx_start) nb++;
         if (nb == 2) reached = 1'b1;
      end
      check("reset_reached_byte2", 32'(reached), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("reset_mid_outputs",
            32'({tx_start, busy, done, ok, err, attempts, echo_valid, echo_byte, tx_data}), 32'd0);
      rst_n = 1'b1;
      cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (tx_start) cnt++;
      end
      check("no_tx_after_reset", 32'(cnt), 32'd0);
   endtask

   vec_t tbl [9];
   vec_t rv;

   initial begin
      n_vec = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; cmd_data = '0; cmd_len = '0;
      rx_ready = 1'b0; rx_data = '0;

      tbl[0] = mk("AT",               2,  pl(1, 0, 0), 0, 0, 0, 1, 0, 0);
      tbl[1] = mk("AT+CSQ",           6,  pl(0, 0, 0), 0, 0, 0, 0, 1, 2);
      tbl[2] = mk("AT+CMGF=1",        9,  pl(2, 1, 0), 0, 0, 0, 1, 0, 1);
      tbl[3] = mk("AT",               2,  pl(0, 0, 1), 1, 0, 0, 1, 0, 2);
      tbl[4] = mk("AT",               0,  pl(1, 1, 1), 0, 0, 0, 0, 1, 0);
      tbl[5] = mk("AT+CGMR=ABCDEFGH", 17, pl(1, 1, 1), 0, 0, 0, 0, 1, 0);
      tbl[6] = mk("ATI",              3,  pl(1, 0, 0), 0, 1, 0, 1, 0, 0);
      tbl[7] = mk("AT&W",             4,  pl(2, 2, 2), 0, 0, 1, 0, 1, 2);
      tbl[8] = mk("AT+CGMR=ABCDEFGH", 16, pl(0, 2, 1), 1, 1, 1, 1, 0, 2);

      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({tx_start, busy, done, ok, err, attempts, echo_valid, echo_byte}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      reset_mid_seq();
      run_vec(tbl[0]);

      for (int n = 0; n < 20; n++) begin
         for (int b = 0; b < CMD_LEN; b++) rv.cmd[8*b +: 8] = 8'($urandom_range(32, 126));
         if ($urandom_range(0, 7) == 0) rv.len = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd17;
         else rv.len = 5'($urandom_range(1, CMD_LEN));
         rv.plan = pl(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         rv.echo = 1'($urandom_range(0, 1));
         rv.restart = 1'($urandom_range(0, 1));
         rv.start_on_done = 1'($urandom_range(0, 1));
         rv = model(rv);
         run_vec(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
